// File: rtl/pkt_pkg.sv
// Shared types for the 13-bit packet link.
// Flit layout, flit type and message status encodings.
package pkt_pkg;

    localparam int PKT_W = 13;

    typedef enum logic [1:0] {
        DATA = 2'b00,
        CTRL = 2'b01,
        NOP  = 2'b10,
        RSVD = 2'b11
    } pkt_type_e;

    typedef enum logic [1:0] {
        OK       = 2'b00,
        LEN_ERR  = 2'b01,
        TYPE_ERR = 2'b10
    } ack_status_e;

    typedef struct packed {
        logic [1:0] dst_addr;
        pkt_type_e  pack_t;
        logic [7:0] payload;
        logic       eop;
    } pkt_t;

endpackage

// File: rtl/pkt_rx_fifo.sv
// First-word-fall-through payload FIFO.
// Extra pointer MSB separates full from empty.
module pkt_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty = (wptr == rptr);
    assign full = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push = wr_en && !full;
    assign pop = rd_en && !empty;
    assign rd_valid = !empty;
    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

    // Advance pointers on accepted writes and reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/pkt_dst_receiver.sv
// Destination endpoint for the 13-bit packet link.
// Filters by address, reassembles messages, buffers DATA payloads.
module pkt_dst_receiver
    import pkt_pkg::*;
#(
    parameter logic [1:0] MY_ADDR = 2'b00,
    parameter int         DEPTH   = 8,
    parameter int         MAX_LEN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PKT_W-1:0] packet,
    input  logic             dst_valid,
    output logic             dst_ready,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             ack,
    output logic [1:0]       ack_status,
    output logic [4:0]       msg_len,
    output logic [7:0]       drop_cnt
);
    typedef enum logic [1:0] {IDLE, RECV, DROP, ACK} rx_state_e;

    localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

    rx_state_e   state;
    ack_status_e status;
    ack_status_e flit_err;
    ack_status_e fin_status;
    logic [4:0]  len;
    logic [4:0]  fin_len;
    logic        ready_en;
    logic        fifo_full;
    logic        collect;
    logic        xfer;
    logic        hit;
    logic        live;
    logic        is_data;
    logic        push;
    logic        fin;
    pkt_t        flit;

    assign flit = pkt_t'(packet);
    assign collect = (state == IDLE) || (state == RECV);
    assign dst_ready = ready_en && (state != ACK) &&
                       (!fifo_full || state == DROP);
    assign xfer = dst_valid && dst_ready;
    assign hit = xfer && (flit.dst_addr == MY_ADDR);
    assign live = hit && (flit.pack_t != NOP);
    assign is_data = (flit.pack_t == DATA);
    assign push = live && collect && is_data && (len != LEN_MAX);
    assign fin = live && flit.eop && (state != ACK);
    assign fin_status = (state == DROP) ? status : flit_err;
    assign fin_len = len + 5'(push);

    // Error carried by the current flit while still collecting.
    always_comb begin
        flit_err = OK;
        if (flit.pack_t == RSVD) begin
            flit_err = TYPE_ERR;
        end else if (is_data && len == LEN_MAX) begin
            flit_err = LEN_ERR;
        end
    end

    // Message reassembly FSM with registered ack outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            status     <= OK;
            len        <= '0;
            ready_en   <= 1'b0;
            ack        <= 1'b0;
            ack_status <= '0;
            msg_len    <= '0;
        end else begin
            ready_en   <= 1'b1;
            ack        <= 1'b0;
            ack_status <= '0;
            msg_len    <= '0;
            if (fin) begin
                state      <= ACK;
                ack        <= 1'b1;
                ack_status <= fin_status;
                msg_len    <= fin_len;
                len        <= '0;
                status     <= OK;
            end else begin
                unique case (state)
                    IDLE, RECV: begin
                        if (live) begin
                            if (flit_err != OK) begin
                                state  <= DROP;
                                status <= flit_err;
                            end else begin
                                state <= RECV;
                                len   <= fin_len;
                            end
                        end
                    end
                    DROP: state <= DROP;
                    ACK: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Count wrong-address flits, holding at the top value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (xfer && flit.dst_addr != MY_ADDR &&
                     drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    pkt_rx_fifo #(
        .WIDTH(8),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (flit.payload),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_pkt_dst_receiver.sv
// Bench for pkt_dst_receiver: vector table, directed corners,
// and randomized traffic against a message-level model.
module tb_pkt_dst_receiver;

    localparam logic [1:0] T_DATA = 2'b00;
    localparam logic [1:0] T_CTRL = 2'b01;
    localparam logic [1:0] T_NOP  = 2'b10;
    localparam logic [1:0] T_RSVD = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] packet = '0;
    logic        dst_valid = 1'b0;
    logic        dst_ready;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        ack;
    logic [1:0]  ack_status;
    logic [4:0]  msg_len;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int pop_mode = 0;
    logic pop_req = 1'b0;

    logic [7:0]  popped[$];
    logic [6:0]  acks[$];
    logic [7:0]  exp_data[$];
    logic [6:0]  exp_acks[$];

    typedef struct {
        logic        vld;
        logic [12:0] pkt;
        logic        rd;
        logic        rdy;
        logic        ak;
        logic [1:0]  st;
        logic [4:0]  ln;
        logic        rv;
        logic [7:0]  rdd;
        logic [7:0]  drp;
    } vec_t;

    vec_t vecs[$];

    pkt_dst_receiver #(
        .MY_ADDR(2'b00),
        .DEPTH(8),
        .MAX_LEN(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .packet    (packet),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ack       (ack),
        .ack_status(ack_status),
        .msg_len   (msg_len),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Consumer side and ack recorder, sampled on the falling edge.
    always @(negedge clk) begin
        logic p;
        p = rd_valid && (pop_req || pop_mode == 1 ||
            (pop_mode == 2 && $urandom_range(0, 1) == 1));
        rd_en = p;
        if (p) popped.push_back(rd_data);
        if (ack) acks.push_back({ack_status, msg_len});
    end

    function automatic logic [12:0] mk(input logic [1:0] a,
                                       input logic [1:0] t,
                                       input logic [7:0] d,
                                       input logic e);
        return {a, t, d, e};
    endfunction

    function automatic vec_t v(input logic vld, input logic [12:0] pkt,
                               input logic rd, input logic rdy,
                               input logic ak, input logic [1:0] st,
                               input logic [4:0] ln, input logic rv,
                               input logic [7:0] rdd, input logic [7:0] drp);
        vec_t r;
        r.vld = vld; r.pkt = pkt; r.rd = rd; r.rdy = rdy; r.ak = ak;
        r.st = st; r.ln = ln; r.rv = rv; r.rdd = rdd; r.drp = drp;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        dst_valid = 1'b0;
        pop_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    // Present one flit and hold it until it is taken.
    task automatic send(input logic [12:0] p);
        int n;
        n = 0;
        dst_valid = 1'b1;
        packet = p;
        while (!dst_ready && n < 300) begin
            tick();
            n++;
        end
        if (!dst_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got ready=0 want ready=1");
        end
        tick();
        dst_valid = 1'b0;
    endtask

    task automatic chk_ack(input string nm, input logic [1:0] st,
                           input logic [4:0] ln);
        chk(nm, {ack, ack_status, msg_len}, {1'b1, st, ln});
    endtask

    // Message-level reference: what a message stores and reports.
    function automatic void model(input logic [12:0] m[$]);
        logic [1:0] st;
        bit err;
        int n;
        st = 2'b00;
        err = 0;
        n = 0;
        foreach (m[j]) begin
            if (err || m[j][10:9] == T_NOP) continue;
            if (m[j][10:9] == T_RSVD) begin
                st = 2'b10;
                err = 1;
            end else if (m[j][10:9] == T_DATA) begin
                if (n == 16) begin
                    st = 2'b01;
                    err = 1;
                end else begin
                    exp_data.push_back(m[j][8:1]);
                    n++;
                end
            end
        end
        exp_acks.push_back({st, 5'(n)});
    endfunction

    initial begin
        logic [12:0] msg[$];
        logic [7:0]  want[$];
        logic [1:0]  t;
        int          n;
        int          r;
        int          wrong;
        bit          lng;

        // Cycle vectors: messages with payload pops and foreign flits.
        vecs.push_back(v(1, mk(0, T_DATA, 8'h11, 0), 0, 1, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(v(1, mk(0, T_DATA, 8'h22, 0), 0, 1, 0, 0, 0, 1, 8'h11, 0));
        vecs.push_back(v(1, mk(0, T_DATA, 8'h33, 1), 0, 1, 0, 0, 0, 1, 8'h11, 0));
        vecs.push_back(v(0, 13'h0, 0, 0, 1, 0, 3, 1, 8'h11, 0));
        vecs.push_back(v(0, 13'h0, 1, 1, 0, 0, 0, 1, 8'h11, 0));
        vecs.push_back(v(0, 13'h0, 1, 1, 0, 0, 0, 1, 8'h22, 0));
        vecs.push_back(v(0, 13'h0, 1, 1, 0, 0, 0, 1, 8'h33, 0));
        vecs.push_back(v(0, 13'h0, 0, 1, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(v(1, mk(1, T_DATA, 8'hA1, 0), 0, 1, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(v(1, mk(0, T_DATA, 8'h44, 0), 0, 1, 0, 0, 0, 0, 8'h00, 1));
        vecs.push_back(v(1, mk(1, T_CTRL, 8'hA2, 1), 0, 1, 0, 0, 0, 1, 8'h44, 1));
        vecs.push_back(v(1, mk(2, T_DATA, 8'hA3, 0), 0, 1, 0, 0, 0, 1, 8'h44, 2));
        vecs.push_back(v(1, mk(0, T_DATA, 8'h55, 1), 0, 1, 0, 0, 0, 1, 8'h44, 3));
        vecs.push_back(v(0, 13'h0, 0, 0, 1, 0, 2, 1, 8'h44, 3));
        vecs.push_back(v(1, mk(3, T_NOP, 8'hA4, 0), 0, 1, 0, 0, 0, 1, 8'h44, 3));
        vecs.push_back(v(1, mk(1, T_DATA, 8'hA5, 1), 0, 1, 0, 0, 0, 1, 8'h44, 4));
        vecs.push_back(v(0, 13'h0, 0, 1, 0, 0, 0, 1, 8'h44, 5));
        vecs.push_back(v(0, 13'h0, 1, 1, 0, 0, 0, 1, 8'h44, 5));
        vecs.push_back(v(0, 13'h0, 1, 1, 0, 0, 0, 1, 8'h55, 5));
        vecs.push_back(v(0, 13'h0, 0, 1, 0, 0, 0, 0, 8'h00, 5));

        // Reset state and ready release.
        #12;
        chk("reset_outputs",
            {dst_ready, ack, ack_status, msg_len, rd_valid, rd_data, drop_cnt},
            32'h0);
        #10;
        reset = 1'b1;
        #1;
        chk("ready_after_release", dst_ready, 0);
        tick();
        chk("ready_one_clock_later", dst_ready, 1);

        foreach (vecs[i]) begin
            dst_valid = vecs[i].vld;
            packet = vecs[i].pkt;
            pop_req = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {dst_ready, ack, ack_status, msg_len, rd_valid, rd_data, drop_cnt},
                {vecs[i].rdy, vecs[i].ak, vecs[i].st, vecs[i].ln,
                 vecs[i].rv, vecs[i].rdd, vecs[i].drp});
            tick();
        end
        dst_valid = 1'b0;
        pop_req = 1'b0;

        // Reset in the middle of a message.
        send(mk(2, T_DATA, 8'hEE, 0));
        acks.delete();
        send(mk(0, T_DATA, 8'h31, 0));
        send(mk(0, T_DATA, 8'h32, 0));
        chk("mid_msg_rd_valid", rd_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs",
            {dst_ready, ack, ack_status, msg_len, rd_valid, rd_data, drop_cnt},
            32'h0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ready_low_at_release", dst_ready, 0);
        tick();
        chk("ready_high_next_clock", dst_ready, 1);
        repeat (3) tick();
        chk("no_ack_after_reset", acks.size(), 0);
        send(mk(0, T_DATA, 8'h77, 1));
        chk_ack("single_data_ack", 2'b00, 5'd1);
        chk("single_data_head", {rd_valid, rd_data}, {1'b1, 8'h77});

        // Backpressure on a full FIFO.
        do_reset();
        popped.delete();
        for (int i = 0; i < 8; i++) send(mk(0, T_DATA, 8'(8'h80 + i), 0));
        chk("full_ready_low", dst_ready, 0);
        dst_valid = 1'b1;
        packet = mk(0, T_DATA, 8'h88, 1);
        tick();
        tick();
        chk("full_held", {dst_ready, ack, rd_data}, {1'b0, 1'b0, 8'h80});
        pop_req = 1'b1;
        @(negedge clk);
        #1;
        chk("full_ready_low_with_rd_en", {rd_en, dst_ready}, {1'b1, 1'b0});
        tick();
        pop_req = 1'b0;
        chk("ready_after_pop", dst_ready, 1);
        tick();
        dst_valid = 1'b0;
        chk_ack("ninth_ack", 2'b00, 5'd9);
        pop_mode = 1;
        repeat (12) tick();
        pop_mode = 0;
        chk("full_pop_count", popped.size(), 9);
        for (int i = 0; i < 9 && i < popped.size(); i++)
            chk($sformatf("full_pop%0d", i), popped[i], 8'h80 + i);

        // Length limit and type errors.
        do_reset();
        popped.delete();
        acks.delete();
        want.delete();
        pop_mode = 1;
        for (int i = 0; i < 16; i++) begin
            send(mk(0, T_DATA, 8'(8'h20 + i), i == 15));
            want.push_back(8'(8'h20 + i));
        end
        chk_ack("len16_ok", 2'b00, 5'd16);
        for (int i = 0; i < 18; i++) begin
            send(mk(0, T_DATA, 8'(8'h40 + i), i == 17));
            if (i < 16) want.push_back(8'(8'h40 + i));
        end
        chk_ack("len18_err", 2'b01, 5'd16);
        send(mk(0, T_DATA, 8'h60, 0));
        send(mk(0, T_DATA, 8'h61, 0));
        send(mk(0, T_RSVD, 8'h62, 0));
        send(mk(0, T_DATA, 8'h63, 0));
        send(mk(0, T_CTRL, 8'h64, 1));
        want.push_back(8'h60);
        want.push_back(8'h61);
        chk_ack("mid_type_err", 2'b10, 5'd2);
        send(mk(0, T_RSVD, 8'h65, 1));
        chk_ack("first_type_err", 2'b10, 5'd0);
        send(mk(0, T_CTRL, 8'h66, 1));
        chk_ack("single_ctrl", 2'b00, 5'd0);
        tick();
        chk("ack_one_cycle", ack, 0);
        repeat (6) tick();
        pop_mode = 0;
        chk("err_ack_count", acks.size(), 5);
        chk("err_pop_count", popped.size(), want.size());
        for (int i = 0; i < want.size() && i < popped.size(); i++)
            if (popped[i] !== want[i]) chk($sformatf("err_pop%0d", i), popped[i], want[i]);
        checks++;

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send(mk(2'(1 + i % 3), 2'(i), 8'(i), 1'(i)));
            if (i == 253) chk("drop_254", drop_cnt, 254);
            if (i == 254) chk("drop_255", drop_cnt, 255);
        end
        chk("drop_sat", drop_cnt, 255);

        // Randomized traffic against the message model.
        do_reset();
        popped.delete();
        acks.delete();
        exp_data.delete();
        exp_acks.delete();
        pop_mode = 2;
        wrong = 0;
        for (int m = 0; m < 40; m++) begin
            msg.delete();
            lng = ($urandom_range(0, 4) == 0);
            n = lng ? $urandom_range(17, 20) : $urandom_range(1, 10);
            for (int j = 0; j < n; j++) begin
                r = $urandom_range(0, 99);
                if (lng) t = (r < 92) ? T_DATA : T_CTRL;
                else if (r < 60) t = T_DATA;
                else if (r < 75) t = T_CTRL;
                else if (r < 93) t = T_NOP;
                else t = T_RSVD;
                if (j == n - 1 && t == T_NOP) t = T_DATA;
                msg.push_back(mk(2'b00, t, 8'($urandom), j == n - 1));
            end
            model(msg);
            foreach (msg[j]) begin
                if ($urandom_range(0, 4) == 0) begin
                    send(mk(2'($urandom_range(1, 3)), 2'($urandom),
                            8'($urandom), 1'($urandom)));
                    wrong++;
                end
                send(msg[j]);
                if ($urandom_range(0, 4) == 0) tick();
            end
        end
        n = 0;
        while ((popped.size() < exp_data.size() || rd_valid ||
                acks.size() < exp_acks.size()) && n < 1000) begin
            tick();
            n++;
        end
        pop_mode = 0;
        chk("rnd_drain", (n < 1000) ? 1 : 0, 1);
        chk("rnd_ack_count", acks.size(), exp_acks.size());
        for (int i = 0; i < acks.size() && i < exp_acks.size(); i++)
            chk($sformatf("rnd_ack%0d", i), acks[i], exp_acks[i]);
        chk("rnd_pop_count", popped.size(), exp_data.size());
        for (int i = 0; i < popped.size() && i < exp_data.size(); i++)
            chk($sformatf("rnd_pop%0d", i), popped[i], exp_data[i]);
        chk("rnd_drop", drop_cnt, (wrong > 255) ? 255 : wrong);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
